// File: rtl/memoria_pkg.sv
// Shared constants and types for the memoria arbiter slice.
package memoria_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

  // Request fields latched at grant time.
  typedef struct packed {
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] din;
  } req_t;

endpackage

// File: rtl/memoria_arbiter_if.sv
// Bundle of the two requester ports, the memory port and the busy flag.
interface memoria_arbiter_if;
  import memoria_pkg::*;

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_add;
  logic [DATA_W-1:0] p0_din;
  logic              p0_ack;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_dout;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_add;
  logic [DATA_W-1:0] p1_din;
  logic              p1_ack;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_dout;

  logic [ADDR_W-1:0] mem_add;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  p0_req, p0_we, p0_add, p0_din,
    input  p1_req, p1_we, p1_add, p1_din,
    input  mem_dout,
    output p0_ack, p0_rvalid, p0_dout,
    output p1_ack, p1_rvalid, p1_dout,
    output mem_add, mem_en, mem_we, mem_din,
    output busy
  );

  // Requesters plus the memory array.
  modport master (
    output p0_req, p0_we, p0_add, p0_din,
    output p1_req, p1_we, p1_add, p1_din,
    output mem_dout,
    input  p0_ack, p0_rvalid, p0_dout,
    input  p1_ack, p1_rvalid, p1_dout,
    input  mem_add, mem_en, mem_we, mem_din,
    input  busy
  );

endinterface

// File: rtl/memoria_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port other than last_gnt wins.
module rr_arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       en_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  // One-hot grant, only while enabled.
  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      if (req0_i && req1_i) begin
        gnt_o = last_gnt_i ? 2'b01 : 2'b10;
      end else if (req0_i) begin
        gnt_o = 2'b01;
      end else if (req1_i) begin
        gnt_o = 2'b10;
      end
    end
  end

endmodule

// File: rtl/memoria_arbiter.sv
// Shares the single-port memoria array between the fetch port (0) and the
// load/store port (1). Every output is a register or a decode of registers.
module memoria_arbiter
  import memoria_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  memoria_arbiter_if.slave  bus
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  req_t              req_q, req_d;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] p0_dout_q, p1_dout_q;
  logic              capture;

  rr_arb2 u_arb (
    .req0_i     (bus.p0_req),
    .req1_i     (bus.p1_req),
    .en_i       (state_q == IDLE),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  // Read data is taken on the final WAIT edge.
  assign capture = (state_q == WAIT) && (cnt_q == 2'd1);

  // State, wait counter, round-robin pointer and latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      req_q      <= req_d;
    end
  end

  // Per-port read data holds until the next read completes on that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_dout_q <= '0;
      p1_dout_q <= '0;
    end else if (capture) begin
      if (req_q.sel == PORT_LS) begin
        p1_dout_q <= bus.mem_dout;
      end else begin
        p0_dout_q <= bus.mem_dout;
      end
    end
  end

  // Next state, counter and grant latching.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    req_d      = req_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d    = ISSUE;
          last_gnt_d = gnt[1];
          if (gnt[1]) begin
            req_d = '{sel: PORT_LS, we: bus.p1_we, add: bus.p1_add, din: bus.p1_din};
          end else begin
            req_d = '{sel: PORT_FETCH, we: bus.p0_we, add: bus.p0_add, din: bus.p0_din};
          end
        end
      end
      ISSUE: begin
        if (req_q.we) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    bus.p0_ack    = (state_q == ISSUE) && (req_q.sel == PORT_FETCH);
    bus.p1_ack    = (state_q == ISSUE) && (req_q.sel == PORT_LS);
    bus.p0_rvalid = (state_q == RESP)  && (req_q.sel == PORT_FETCH);
    bus.p1_rvalid = (state_q == RESP)  && (req_q.sel == PORT_LS);
    bus.p0_dout   = p0_dout_q;
    bus.p1_dout   = p1_dout_q;
    bus.mem_en    = (state_q == ISSUE);
    bus.mem_we    = (state_q == ISSUE) && req_q.we;
    bus.mem_add   = req_q.add;
    bus.mem_din   = req_q.din;
    bus.busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_memoria_arbiter.sv
// Scoreboard bench for memoria_arbiter: default-latency instance plus a
// MEM_LAT=3 instance, each in front of a behavioural memory model.
module tb_memoria_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    bit          port;
    int          cyc;
    logic [4:0]  add;
    bit          we;
    logic [13:0] din;
  } ack_t;

  typedef struct {
    int          cyc;
    logic [13:0] d;
  } rv_t;

  logic clk;
  logic rst;
  logic rst_b;
  int   cyc;
  int   checks;
  int   errors;

  ack_t ack_q[$];
  rv_t  rv0_q[$];
  rv_t  rv1_q[$];

  int   b_ack_cyc, b_rv_cyc;
  int   b_ack_seen, b_rv_seen;

  logic        pre_en;
  logic [4:0]  pre_add;
  logic [13:0] pre_dat;

  memoria_arbiter_if ifa ();
  memoria_arbiter_if ifb ();

  memoria_arbiter #(.MEM_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst),   .bus(ifa));
  memoria_arbiter #(.MEM_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: writes commit on the enable edge; read data appears
  // MEM_LAT cycles later and is zero otherwise.
  logic [13:0] mema [32];
  logic [13:0] memb [32];
  logic [13:0] pipa;
  logic [13:0] pipb [3];

  always @(posedge clk) begin
    if (pre_en) begin
      mema[pre_add] <= pre_dat;
      memb[pre_add] <= pre_dat;
    end else begin
      if (ifa.mem_en && ifa.mem_we) mema[ifa.mem_add] <= ifa.mem_din;
      if (ifb.mem_en && ifb.mem_we) memb[ifb.mem_add] <= ifb.mem_din;
    end
    pipa    <= (ifa.mem_en && !ifa.mem_we) ? mema[ifa.mem_add] : 14'h0;
    pipb[0] <= (ifb.mem_en && !ifb.mem_we) ? memb[ifb.mem_add] : 14'h0;
    pipb[1] <= pipb[0];
    pipb[2] <= pipb[1];
  end

  assign ifa.mem_dout = pipa;
  assign ifb.mem_dout = pipb[2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return {10'd0, ifa.p0_ack, ifa.p0_rvalid, ifa.p0_dout, ifa.p1_ack, ifa.p1_rvalid,
            ifa.p1_dout, ifa.mem_add, ifa.mem_en, ifa.mem_we, ifa.mem_din, ifa.busy};
  endfunction

  function automatic logic [63:0] outs_b();
    return {10'd0, ifb.p0_ack, ifb.p0_rvalid, ifb.p0_dout, ifb.p1_ack, ifb.p1_rvalid,
            ifb.p1_dout, ifb.mem_add, ifb.mem_en, ifb.mem_we, ifb.mem_din, ifb.busy};
  endfunction

  // Monitor for instance A: acks, memory strobes and read returns.
  always @(negedge clk) begin
    ack_t e;
    rv_t  r;
    if (ifa.p0_ack || ifa.p1_ack) begin
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected got p0_ack=%0b p1_ack=%0b exp none (cycle %0d)",
                 ifa.p0_ack, ifa.p1_ack, cyc);
      end else begin
        e = ack_q.pop_front();
        chk("ack", {9'd0, ifa.p0_ack, ifa.p1_ack, 32'(cyc), ifa.mem_en, ifa.mem_add,
                    ifa.mem_we, ifa.mem_din},
                   {9'd0, !e.port, e.port, 32'(e.cyc), 1'b1, e.add, e.we, e.din});
      end
    end
    if (ifa.mem_en && !(ifa.p0_ack || ifa.p1_ack)) begin
      chk("mem_en_without_ack", {63'd0, ifa.mem_en}, 64'd0);
    end
    if (ifa.p0_rvalid) begin
      if (rv0_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p0_rvalid_unexpected got dout %0h exp none (cycle %0d)", ifa.p0_dout, cyc);
      end else begin
        r = rv0_q.pop_front();
        chk("p0_rvalid", {18'd0, ifa.p1_rvalid, 32'(cyc), ifa.p0_dout},
                         {18'd0, 1'b0, 32'(r.cyc), r.d});
      end
    end
    if (ifa.p1_rvalid) begin
      if (rv1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p1_rvalid_unexpected got dout %0h exp none (cycle %0d)", ifa.p1_dout, cyc);
      end else begin
        r = rv1_q.pop_front();
        chk("p1_rvalid", {18'd0, ifa.p0_rvalid, 32'(cyc), ifa.p1_dout},
                         {18'd0, 1'b0, 32'(r.cyc), r.d});
      end
    end
  end

  // Monitor for instance B (MEM_LAT=3).
  always @(negedge clk) begin
    if (ifb.p0_ack) begin
      b_ack_seen++;
      chk("b_ack", {26'd0, 32'(cyc), ifb.mem_en, ifb.mem_add}, {26'd0, 32'(b_ack_cyc), 1'b1, 5'd0});
    end
    if (ifb.mem_en && !ifb.p0_ack) begin
      chk("b_mem_en_in_wait", {63'd0, ifb.mem_en}, 64'd0);
    end
    if (ifb.p0_rvalid) begin
      b_rv_seen++;
      chk("b_rvalid", {18'd0, 32'(cyc), ifb.p0_dout}, {18'd0, 32'(b_rv_cyc), 14'h0155});
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [4:0] add, input logic [13:0] din);
    if (port) begin
      ifa.p1_req = req; ifa.p1_we = we; ifa.p1_add = add; ifa.p1_din = din;
    end else begin
      ifa.p0_req = req; ifa.p0_we = we; ifa.p0_add = add; ifa.p0_din = din;
    end
  endtask

  task automatic preload(input logic [4:0] add, input logic [13:0] dat);
    pre_en = 1'b1; pre_add = add; pre_dat = dat;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // One transaction from an idle DUT. rst_off != 0 asserts reset during
  // cycle (start + rst_off); a read interrupted that way returns nothing.
  task automatic issue(input bit port, input bit we, input logic [4:0] add,
                       input logic [13:0] din, input logic [13:0] exp_d, input int rst_off);
    int c;
    c = cyc;
    drive(port, 1'b1, we, add, din);
    ack_q.push_back('{port, c + 1, add, we, din});
    if (!we && rst_off == 0) begin
      if (port) rv1_q.push_back('{c + 2 + LAT_A, exp_d});
      else      rv0_q.push_back('{c + 2 + LAT_A, exp_d});
    end
    @(posedge clk); #1;
    drive(port, 1'b0, we, add, din);
    if (rst_off != 0) begin
      while (cyc < c + rst_off) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_mid_op_outputs_zero", outs_a(), 64'd0);
    end else begin
      repeat (we ? 1 : 2 + LAT_A) begin @(posedge clk); #1; end
      chk("busy_low_after_txn", {63'd0, ifa.busy}, 64'd0);
    end
  endtask

  initial begin
    int c;
    cyc = 0; checks = 0; errors = 0;
    b_ack_cyc = -1; b_rv_cyc = -1; b_ack_seen = 0; b_rv_seen = 0;
    pre_en = 1'b0; pre_add = '0; pre_dat = '0;
    rst = 1'b1; rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 14'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 14'd0);
    ifb.p0_req = 1'b0; ifb.p0_we = 1'b0; ifb.p0_add = '0; ifb.p0_din = '0;
    ifb.p1_req = 1'b0; ifb.p1_we = 1'b0; ifb.p1_add = '0; ifb.p1_din = '0;
    @(posedge clk); #1;
    preload(5'd5, 14'h02A5);
    preload(5'd0, 14'h0155);
    rst = 1'b0; rst_b = 1'b0;
    chk("reset_outputs_a", outs_a(), 64'd0);
    chk("reset_outputs_b", outs_b(), 64'd0);

    // Single read on the fetch port.
    issue(1'b0, 1'b0, 5'd5, 14'd0, 14'h02A5, 0);

    // Write then read back on the load/store port.
    issue(1'b1, 1'b1, 5'd31, 14'h3FFF, 14'd0, 0);
    issue(1'b1, 1'b0, 5'd31, 14'd0, 14'h3FFF, 0);
    chk("p0_dout_untouched", {50'd0, ifa.p0_dout}, {50'd0, 14'h02A5});

    // MEM_LAT=3 instance: ack in cycle 1, rvalid in cycle 5, idle in cycle 6.
    c = cyc;
    b_ack_cyc = c + 1;
    b_rv_cyc  = c + 2 + LAT_B;
    ifb.p0_req = 1'b1; ifb.p0_we = 1'b0; ifb.p0_add = 5'd0;
    @(posedge clk); #1;
    ifb.p0_req = 1'b0;
    repeat (2 + LAT_B) begin @(posedge clk); #1; end
    chk("b_busy_low", {63'd0, ifb.busy}, 64'd0);

    // Fresh reset, then both ports request reads continuously.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c = cyc;
    drive(1'b0, 1'b1, 1'b0, 5'd5,  14'h0AAA);
    drive(1'b1, 1'b1, 1'b0, 5'd31, 14'h1555);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        ack_q.push_back('{1'b0, c + 1 + 4 * k, 5'd5, 1'b0, 14'h0AAA});
        rv0_q.push_back('{c + 3 + 4 * k, 14'h02A5});
      end else begin
        ack_q.push_back('{1'b1, c + 1 + 4 * k, 5'd31, 1'b0, 14'h1555});
        rv1_q.push_back('{c + 3 + 4 * k, 14'h3FFF});
      end
    end
    while (cyc < c + 13) begin @(posedge clk); #1; end
    drive(1'b0, 1'b0, 1'b0, 5'd5,  14'h0AAA);
    drive(1'b1, 1'b0, 1'b0, 5'd31, 14'h1555);
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_low_after_tie", {63'd0, ifa.busy}, 64'd0);

    // Reset in WAIT of a fetch read, then a normal load/store read.
    issue(1'b0, 1'b0, 5'd5, 14'd0, 14'd0, 2);
    issue(1'b1, 1'b0, 5'd31, 14'd0, 14'h3FFF, 0);

    // Reset in ISSUE of a write still commits it.
    issue(1'b0, 1'b1, 5'd7, 14'h1234, 14'd0, 1);
    repeat (2) begin @(posedge clk); #1; end
    issue(1'b1, 1'b0, 5'd7, 14'd0, 14'h1234, 0);

    repeat (4) begin @(posedge clk); #1; end
    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    chk("p0_rv_queue_drained", 64'(rv0_q.size()), 64'd0);
    chk("p1_rv_queue_drained", 64'(rv1_q.size()), 64'd0);
    chk("b_ack_count", 64'(b_ack_seen), 64'd1);
    chk("b_rvalid_count", 64'(b_rv_seen), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memoria_arbiter.md
Name: memoria_arbiter

Overview:
Two-port arbitrated controller in front of the 32 x 14-bit `memoria` array. It shares the array between the instruction-fetch port (port 0) and the load/store port (port 1). Each request is captured, sequenced onto the single memory port (add/en/we/data_in), and for reads the 14-bit data is returned with a one-cycle valid pulse. It sits between the CPU fetch/execute units and `memoria`. It is the only driver of the memory's inputs.

Parameters:
- ADDR_W, 5: memory address width (32 words).
- DATA_W, 14: memory/instruction word width.
- MEM_LAT, 1: cycles from the edge that samples mem_en=1 until mem_dout is valid. Legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_add  in  ADDR_W  port 0 address.
- p0_din  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle pulse: port 0 request accepted.
- p0_rvalid  out  1  one-cycle pulse: p0_dout valid.
- p0_dout  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_add, p1_din, p1_ack, p1_rvalid, p1_dout: same as port 0, for port 1.
- mem_add  out  ADDR_W  to memoria add.
- mem_en  out  1  to memoria en.
- mem_we  out  1  to memoria write enable.
- mem_din  out  DATA_W  to memoria data_in.
- mem_dout  in  DATA_W  from memoria data_out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; wait counter is 0.
  - last_gnt=1, so port 0 wins the first tie.
  - All outputs go to 0, including pX_dout, mem_add and mem_din.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded only from registered state. No combinational path from any input to any output.
- IDLE:
  - Samples p0_req/p1_req. With no request, stays in IDLE.
  - Only one requesting: that port is granted.
  - Both requesting: the port != last_gnt is granted (round-robin). last_gnt updates on every grant.
  - On a grant, latches sel, we, add and din of the granted port, then goes to ISSUE.
- ISSUE (exactly 1 cycle):
  - pSEL_ack=1; mem_en=1.
  - mem_add, mem_we and mem_din carry the latched values.
  - Write: next state is IDLE.
  - Read: next state is WAIT, with the counter loaded to MEM_LAT.
- WAIT:
  - The counter decrements each cycle. When it reaches 1, mem_dout is captured into pSEL_dout at that edge and the FSM goes to RESP.
  - mem_en=0 throughout.
- RESP (1 cycle): pSEL_rvalid=1 with pSEL_dout stable; next state is IDLE.
- pX_dout holds its last read value until the next read on that port. The non-granted port's outputs never change.
- Latency, counting the request-sampled-in-IDLE cycle as cycle 0:
  - ack and mem_en in cycle 1.
  - Read: rvalid in cycle 2+MEM_LAT (cycle 3 at default), then IDLE in cycle 3+MEM_LAT.
  - Write: done after ISSUE; IDLE in cycle 2.
- Throughput: read every 3+MEM_LAT cycles; write every 2 cycles.
- Requests are sampled only in IDLE. A requester must drop req in its ack cycle. A req still high in the cycle after ack is treated as a new request.
- A req that drops before ack, without ever being sampled in IDLE, is never serviced. Once latched, a request always completes (barring reset).
- Address wrap: none. All 32 addresses are valid, and pX_add is used unmodified.
- Simultaneous requests to the same address: serialized in grant order. A write granted first is visible to a following read.
- Reset mid-operation:
  - rst during ISSUE: mem_en is still 1 for that cycle, so a write commits. State is IDLE after the edge.
  - rst during WAIT/RESP: the pending rvalid is suppressed.
  - In all cases no ack or rvalid appears after reset.

Decomposition:
- Package memoria_pkg:
  - ADDR_W=5 and DATA_W=14 constants.
  - State encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - Port index constants PORT_FETCH=0 and PORT_LS=1.
- One sub-module, rr_arb2:
  - Inputs: two requests, the grant-enable strobe, and the last_gnt register.
  - Outputs: the one-hot grant.
  - Shared with future bus arbiters.

Test Plan:
- Single read: preload addr 5 = 14'h2A5; p0 read addr 5 → p0_ack in cycle 1, mem_en=1/mem_add=5 in cycle 1, p0_rvalid in cycle 3 with p0_dout=14'h2A5, busy low in cycle 4.
- Write then read: p1 writes 14'h3FFF to addr 31 → p1_ack cycle 1, mem_we=1; then p1 reads addr 31 → p1_dout=14'h3FFF; p0 outputs unchanged.
- Tie and round-robin: after reset, p0 and p1 both request reads continuously → grants alternate p0,p1,p0,p1. Each rvalid appears only on the granted port, with no overlap.
- MEM_LAT=3 build: read addr 0 holding 14'h0155 → rvalid in cycle 5 with the correct data; no mem_en during WAIT.
- Reset mid-read: assert rst in the WAIT cycle of a p0 read → no p0_rvalid, busy=0 and all outputs 0 next cycle; a new p1 request is then serviced normally.
- Reset in ISSUE of a write (addr 7, 14'h1234) → a later read of addr 7 returns 14'h1234; no p0_ack/rvalid after reset.
